uart_status_tx: RTL and testbench

Serial status reporter for the digital clock: once per second it snapshots the current time and DHT11 temperature/humidity and transmits them as a fixed 16-character ASCII line on a dedicated UART TX pin, 8N1 LSB-first. It is the transmit-side counterpart of the command receiver, sits beside it at the top level, shares `clk`/`rst_n`/`clk_1Hz_en`, and lets the host PC read back the clock state it configured.

---
 rtl/uart_status_tx.sv | 194 +++++++++++++++++++
 tb/tb_uart_status_tx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_status_tx.sv
// uart_status_tx: once per trigger, sends the snapshot time and DHT11 readings
// as the 16-byte ASCII line "HH:MM:SS,TT,RR\r\n" over an 8N1, LSB-first UART.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit after the
// data bits of every byte.
module uart_status_tx #(
    parameter int CLK_FREQ = 27_000_000,
    parameter int BAUD     = 115200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_1Hz_en,
    input  logic [5:0]  hour_decimal,
    input  logic [5:0]  minute_decimal,
    input  logic [5:0]  second_decimal,
    input  logic [31:0] TempHumi,
    output logic        uart_txd,
    output logic        tx_busy
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CNT_W    = $clog2(BAUD_DIV + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP, S_NEXT
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_DATA, S_STOP, S_NEXT
    } state_t;
`endif

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [3:0]       byte_idx;
    logic             baud_done;
    logic             bit_timed;
    logic [7:0]       tx_byte;

    logic [5:0]       snap_hour;
    logic [5:0]       snap_min;
    logic [5:0]       snap_sec;
    logic [7:0]       snap_temp;
    logic [7:0]       snap_humi;
    logic [7:0]       bcd_h;
    logic [7:0]       bcd_m;
    logic [7:0]       bcd_s;
    logic [7:0]       bcd_t;
    logic [7:0]       bcd_r;

    // The fraction bytes of the DHT11 word are deliberately never transmitted.
    logic unused_fraction;
    assign unused_fraction = ^{TempHumi[23:16], TempHumi[7:0]};

    // Two decimal digits {tens, units}; anything above 99 saturates to 99.
    function automatic logic [7:0] to_bcd(input logic [7:0] value);
        logic [7:0] clamped;
        clamped = (value > 8'd99) ? 8'd99 : value;
        return {4'(clamped / 8'd10), 4'(clamped % 8'd10)};
    endfunction

    assign baud_done = (baud_cnt == CNT_LAST);
    assign tx_busy   = (state != S_IDLE);

    // Select the ASCII character for the current byte position of the line.
    always_comb begin
        tx_byte = 8'h0A;
        case (byte_idx)
            4'd0:    tx_byte = {4'h3, bcd_h[7:4]};
            4'd1:    tx_byte = {4'h3, bcd_h[3:0]};
            4'd2:    tx_byte = 8'h3A;
            4'd3:    tx_byte = {4'h3, bcd_m[7:4]};
            4'd4:    tx_byte = {4'h3, bcd_m[3:0]};
            4'd5:    tx_byte = 8'h3A;
            4'd6:    tx_byte = {4'h3, bcd_s[7:4]};
            4'd7:    tx_byte = {4'h3, bcd_s[3:0]};
            4'd8:    tx_byte = 8'h2C;
            4'd9:    tx_byte = {4'h3, bcd_t[7:4]};
            4'd10:   tx_byte = {4'h3, bcd_t[3:0]};
            4'd11:   tx_byte = 8'h2C;
            4'd12:   tx_byte = {4'h3, bcd_r[7:4]};
            4'd13:   tx_byte = {4'h3, bcd_r[3:0]};
            4'd14:   tx_byte = 8'h0D;
            default: tx_byte = 8'h0A;
        endcase
    end

    // Next-state logic and line level; the line idles high outside bit states.
    always_comb begin
        state_next = state;
        uart_txd   = 1'b1;
        bit_timed  = 1'b0;
        case (state)
            S_IDLE: begin
                if (clk_1Hz_en) state_next = S_LOAD;
            end
            S_LOAD: begin
                state_next = S_START;
            end
            S_START: begin
                uart_txd  = 1'b0;
                bit_timed = 1'b1;
                if (baud_done) state_next = S_DATA;
            end
            S_DATA: begin
                uart_txd  = tx_byte[bit_idx];
                bit_timed = 1'b1;
                if (baud_done && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_next = S_PARITY;
`else
                    state_next = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                uart_txd  = ^tx_byte;
                bit_timed = 1'b1;
                if (baud_done) state_next = S_STOP;
            end
`endif
            S_STOP: begin
                bit_timed = 1'b1;
                if (baud_done) state_next = S_NEXT;
            end
            S_NEXT: begin
                state_next = (byte_idx == 4'd15) ? S_IDLE : S_START;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Bit-period counter plus bit and byte position within the frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
        end else begin
            if (bit_timed) baud_cnt <= baud_done ? '0 : baud_cnt + 1'b1;
            else           baud_cnt <= '0;

            if (state != S_DATA)  bit_idx <= '0;
            else if (baud_done)   bit_idx <= bit_idx + 1'b1;

            if (state == S_LOAD)      byte_idx <= '0;
            else if (state == S_NEXT) byte_idx <= byte_idx + 1'b1;
        end
    end

    // Capture the inputs on the accepted trigger and convert them during LOAD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snap_hour <= '0;
            snap_min  <= '0;
            snap_sec  <= '0;
            snap_temp <= '0;
            snap_humi <= '0;
            bcd_h     <= '0;
            bcd_m     <= '0;
            bcd_s     <= '0;
            bcd_t     <= '0;
            bcd_r     <= '0;
        end else begin
            if (state == S_IDLE && clk_1Hz_en) begin
                snap_hour <= hour_decimal;
                snap_min  <= minute_decimal;
                snap_sec  <= second_decimal;
                snap_temp <= TempHumi[15:8];
                snap_humi <= TempHumi[31:24];
            end
            if (state == S_LOAD) begin
                bcd_h <= to_bcd({2'b00, snap_hour});
                bcd_m <= to_bcd({2'b00, snap_min});
                bcd_s <= to_bcd({2'b00, snap_sec});
                bcd_t <= to_bcd(snap_temp);
                bcd_r <= to_bcd(snap_humi);
            end
        end
    end

endmodule

// File: tb/tb_uart_status_tx.sv
// Testbench for uart_status_tx: one instance at the default 234-cycle bit
// period and one with a 4-cycle bit period; a UART monitor decodes whichever
// is selected and compares each byte against a queue of expected characters.
module tb_uart_status_tx;

    localparam int DIV_A = 27_000_000 / 115200;
    localparam int DIV_B = 4;
`ifdef UART_TX_PARITY_EN
    localparam int BITS = 11;
`else
    localparam int BITS = 10;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_a = 1'b0;
    logic        en_b = 1'b0;
    logic [5:0]  hour = '0;
    logic [5:0]  minute = '0;
    logic [5:0]  second = '0;
    logic [31:0] temp_humi = '0;
    logic        txd_a, busy_a, txd_b, busy_b;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  exp_q[$];
    logic        mon_en = 1'b0;
    logic        mon_sel = 1'b0;
    logic        mon_line;
    int          mon_div;

    assign mon_line = mon_sel ? txd_b : txd_a;
    assign mon_div  = mon_sel ? DIV_B : DIV_A;

    uart_status_tx dut_a (
        .clk(clk), .rst_n(rst_n), .clk_1Hz_en(en_a),
        .hour_decimal(hour), .minute_decimal(minute), .second_decimal(second),
        .TempHumi(temp_humi), .uart_txd(txd_a), .tx_busy(busy_a)
    );

    uart_status_tx #(.CLK_FREQ(460800), .BAUD(115200)) dut_b (
        .clk(clk), .rst_n(rst_n), .clk_1Hz_en(en_b),
        .hour_decimal(hour), .minute_decimal(minute), .second_decimal(second),
        .TempHumi(temp_humi), .uart_txd(txd_b), .tx_busy(busy_b)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic selBusy(input bit sel_b);
        return sel_b ? busy_b : busy_a;
    endfunction

    function automatic logic selTxd(input bit sel_b);
        return sel_b ? txd_b : txd_a;
    endfunction

    // Called at a negedge: drives the inputs, pulses the trigger across one
    // posedge and queues the expected line; returns at the negedge after it.
    task automatic applyStimulus(input logic [5:0] h, input logic [5:0] m,
                                 input logic [5:0] s, input logic [31:0] th,
                                 input bit sel_b, input string text);
        hour = h; minute = m; second = s; temp_humi = th;
        for (int i = 0; i < text.len(); i++) exp_q.push_back(8'(text[i]));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        if (sel_b) en_b = 1'b1; else en_a = 1'b1;
        @(negedge clk);
        en_a = 1'b0;
        en_b = 1'b0;
    endtask

    // Counts busy cycles from the LOAD cycle onward, checking the start bit.
    task automatic measureFrame(input bit sel_b, input int div, input string name);
        int cnt;
        int expected_len;
        cnt = 0;
        expected_len = 16 * (BITS * div + 1) + 1;
        while (selBusy(sel_b) === 1'b1 && cnt <= expected_len + 20) begin
            cnt++;
            if (cnt == 1) checkOutput({name, "_load_txd"}, 32'(selTxd(sel_b)), 32'd1);
            if (cnt == 2) checkOutput({name, "_start_bit"}, 32'(selTxd(sel_b)), 32'd0);
            @(negedge clk);
        end
        checkOutput({name, "_busy_cycles"}, cnt, expected_len);
    endtask

    // Monitor: decode UART bytes mid-bit and compare against the queue.
    initial begin : monitor
        logic [7:0] data;
        logic       start_lvl;
        logic       stop_lvl;
        logic       par;
        logic [7:0] expected;
        par = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && mon_line === 1'b0) begin
                repeat (mon_div / 2) @(negedge clk);
                start_lvl = mon_line;
                for (int i = 0; i < 8; i++) begin
                    repeat (mon_div) @(negedge clk);
                    data[i] = mon_line;
                end
`ifdef UART_TX_PARITY_EN
                repeat (mon_div) @(negedge clk);
                par = mon_line;
`endif
                repeat (mon_div) @(negedge clk);
                stop_lvl = mon_line;
                if (mon_en) begin
                    checkOutput("start_bit_mid", 32'(start_lvl), 32'd0);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_byte: got 0x%0h expected none", data);
                    end else begin
                        expected = exp_q.pop_front();
                        checkOutput("rx_byte", 32'(data), 32'(expected));
                    end
`ifdef UART_TX_PARITY_EN
                    checkOutput("parity_bit", 32'(par), 32'(^data));
`endif
                    checkOutput("stop_bit", 32'(stop_lvl), 32'd1);
                end
            end
        end
    end

    initial begin : watchdog
        repeat (95000) @(posedge clk);
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin : stimulus
        logic idle_err;
        repeat (3) @(negedge clk);
        checkOutput("reset_txd_a", 32'(txd_a), 32'd1);
        checkOutput("reset_busy_a", 32'(busy_a), 32'd0);
        checkOutput("reset_txd_b", 32'(txd_b), 32'd1);
        checkOutput("reset_busy_b", 32'(busy_b), 32'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Idle line for 10000 cycles with no trigger.
        idle_err = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (txd_a !== 1'b1 || busy_a !== 1'b0 || txd_b !== 1'b1 || busy_b !== 1'b0)
                idle_err = 1'b1;
        end
        checkOutput("idle_quiet", 32'(idle_err), 32'd0);

        // Full-speed frame at the default divider.
        $display("[TB] frame at default bit period");
        applyStimulus(6'd12, 6'd34, 6'd56, 32'h3C00_1900, 1'b0, "12:34:56,25,60");
        checkOutput("busy_after_trigger", 32'(busy_a), 32'd1);
        measureFrame(1'b0, DIV_A, "frame_a");
        repeat (10) @(negedge clk);
        checkOutput("frame_a_drained", exp_q.size(), 0);

        // Leading zeros and clamping on the fast instance.
        mon_sel = 1'b1;
        repeat (10) @(negedge clk);
        applyStimulus(6'd5, 6'd0, 6'd7, 32'hC800_FF00, 1'b1, "05:00:07,99,99");
        measureFrame(1'b1, DIV_B, "clamp");
        repeat (10) @(negedge clk);
        checkOutput("clamp_drained", exp_q.size(), 0);

        // Mid-frame trigger and input change must not disturb the frame.
        applyStimulus(6'd23, 6'd59, 6'd9, 32'h2D00_1200, 1'b1, "23:59:09,18,45");
        fork
            measureFrame(1'b1, DIV_B, "retrig");
            begin
                repeat (100) @(negedge clk);
                hour = 6'd1; minute = 6'd2; second = 6'd3; temp_humi = 32'h1111_1111;
                en_b = 1'b1;
                @(negedge clk);
                en_b = 1'b0;
            end
        join
        checkOutput("retrig_drained", exp_q.size(), 0);

        // Trigger in the very cycle IDLE is re-entered is accepted.
        applyStimulus(6'd1, 6'd2, 6'd3, 32'h1111_1111, 1'b1, "01:02:03,17,17");
        checkOutput("same_cycle_trigger", 32'(busy_b), 32'd1);

        // Reset a few cycles into byte 7.
        repeat (6 + 7 * (BITS * DIV_B + 1)) @(negedge clk);
        checkOutput("bytes_left_before_reset", exp_q.size(), 9);
        mon_en = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("reset_mid_txd", 32'(txd_b), 32'd1);
        checkOutput("reset_mid_busy", 32'(busy_b), 32'd0);
        en_b = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        en_b = 1'b0;
        @(negedge clk);
        checkOutput("trigger_in_reset_ignored", 32'(busy_b), 32'd0);
        exp_q.delete();
        repeat (60) @(negedge clk);
        checkOutput("idle_after_reset", 32'(txd_b), 32'd1);
        mon_en = 1'b1;

        // A fresh, complete frame after the reset.
        applyStimulus(6'd10, 6'd20, 6'd30, 32'h3700_1500, 1'b1, "10:20:30,21,55");
        measureFrame(1'b1, DIV_B, "fresh");
        repeat (10) @(negedge clk);
        checkOutput("fresh_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
